// File: rtl/sound_cmd_latch.sv
// 68k -> Z80 sound-command FIFO with a Z80 interrupt raised while commands are pending.
// Define SOUND_REPLY_EN to add the Z80 -> 68k reply byte (and the z80_din port).
module sound_cmd_latch #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     m68k_latch_cs,
  input  logic [7:0]               m68k_din,
  input  logic                     z80_latch_cs,
  input  logic                     RD_n,
  input  logic                     WR_n,
`ifdef SOUND_REPLY_EN
  input  logic [7:0]               z80_din,
`endif
  output logic [7:0]               z80_dout,
  output logic                     z80_irq_n,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     m68k_reply_cs,
  output logic [7:0]               m68k_reply,
  output logic                     reply_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_last_rd;
  logic          r_irq_n;
  logic          r_overflow;
  logic          r_cs_q;
  logic          r_rsel_q;

  logic w_push_req;
  logic w_rsel;
  logic w_pop;
  logic w_full;
  logic w_push;

  assign w_push_req = m68k_latch_cs & ~r_cs_q;
  assign w_rsel     = z80_latch_cs & ~RD_n;
  assign w_full     = (r_count == FULL_CNT);
  // Pop on the trailing edge of the read so the head is stable for the whole Z80 read.
  assign w_pop      = ~w_rsel & r_rsel_q & (r_count != '0);
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_last_rd  <= '0;
      r_irq_n    <= 1'b1;
      r_overflow <= 1'b0;
      r_cs_q     <= 1'b0;
      r_rsel_q   <= 1'b0;
    end else begin
      r_cs_q   <= m68k_latch_cs;
      r_rsel_q <= w_rsel;
      r_irq_n  <= (r_count == '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_last_rd <= r_mem[r_rd_ptr];
      end
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= m68k_din;
  end

  assign z80_dout   = (r_count != '0) ? r_mem[r_rd_ptr] : r_last_rd;
  assign z80_irq_n  = r_irq_n;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

`ifdef SOUND_REPLY_EN
  logic [7:0] r_reply;
  logic       r_reply_pending;
  logic       r_wsel_q;
  logic       r_rcs_q;
  logic       w_wsel;
  logic       w_set;
  logic       w_clr;

  assign w_wsel = z80_latch_cs & ~WR_n;
  assign w_set  = w_wsel & ~r_wsel_q;
  assign w_clr  = m68k_reply_cs & ~r_rcs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reply         <= '0;
      r_reply_pending <= 1'b0;
      r_wsel_q        <= 1'b0;
      r_rcs_q         <= 1'b0;
    end else begin
      r_wsel_q <= w_wsel;
      r_rcs_q  <= m68k_reply_cs;
      if (w_set) begin
        r_reply         <= z80_din;
        r_reply_pending <= 1'b1;
      end else if (w_clr) begin
        r_reply_pending <= 1'b0;
      end
    end
  end

  assign m68k_reply    = r_reply;
  assign reply_pending = r_reply_pending;
`else
  logic w_unused_reply;
  assign w_unused_reply = WR_n ^ m68k_reply_cs;
  assign m68k_reply     = '0;
  assign reply_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_sound_cmd_latch.sv
// Scoreboard bench for sound_cmd_latch: stimulus queues expected read bytes, a monitor
// compares z80_dout throughout every Z80 read; status outputs are checked inline.
module tb_sound_cmd_latch;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m68k_latch_cs;
  logic [7:0] m68k_din;
  logic       z80_latch_cs;
  logic       RD_n;
  logic       WR_n;
  logic [7:0] z80_dout;
  logic       z80_irq_n;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       m68k_reply_cs;
  logic [7:0] m68k_reply;
  logic       reply_pending;
`ifdef SOUND_REPLY_EN
  logic [7:0] z80_din;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sound_cmd_latch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m68k_latch_cs (m68k_latch_cs),
    .m68k_din      (m68k_din),
    .z80_latch_cs  (z80_latch_cs),
    .RD_n          (RD_n),
    .WR_n          (WR_n),
`ifdef SOUND_REPLY_EN
    .z80_din       (z80_din),
`endif
    .z80_dout      (z80_dout),
    .z80_irq_n     (z80_irq_n),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .m68k_reply_cs (m68k_reply_cs),
    .m68k_reply    (m68k_reply),
    .reply_pending (reply_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m68k_write(input logic [7:0] b, input int hold);
    m68k_din = b;
    m68k_latch_cs = 1'b1;
    tick(hold);
    m68k_latch_cs = 1'b0;
    tick(1);
  endtask

  task automatic z80_read(input logic [7:0] exp);
    exp_q.push_back(exp);
    z80_latch_cs = 1'b1;
    RD_n = 1'b0;
    tick(3);
    RD_n = 1'b1;
    z80_latch_cs = 1'b0;
    tick(1);
  endtask

  // Monitor: during a read the head must match the queued byte; retire it when the read ends.
  logic mon_rsel_q = 1'b0;
  always @(negedge clk) begin
    logic rsel;
    rsel = z80_latch_cs & ~RD_n;
    if (rsel) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL read_unexpected: got %0h expected none", z80_dout);
      end else begin
        check("read_dout", {24'h0, z80_dout}, {24'h0, exp_q[0]});
      end
    end else if (mon_rsel_q && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    mon_rsel_q = rsel;
  end

  initial begin
    reset_n = 1'b0; m68k_latch_cs = 1'b0; m68k_din = '0;
    z80_latch_cs = 1'b0; RD_n = 1'b1; WR_n = 1'b1; m68k_reply_cs = 1'b0;
`ifdef SOUND_REPLY_EN
    z80_din = '0;
`endif
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("rst_irq_n", {31'h0, z80_irq_n}, 32'h1);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_dout", {24'h0, z80_dout}, 32'h0);

    // Single long write: one push only, irq one clock after the push edge
    m68k_din = 8'h5A; m68k_latch_cs = 1'b1;
    tick(1);
    check("push_count", {29'h0, fifo_count}, 32'h1);
    check("push_irq_still_hi", {31'h0, z80_irq_n}, 32'h1);
    tick(1);
    check("push_irq_lo", {31'h0, z80_irq_n}, 32'h0);
    tick(2);
    m68k_latch_cs = 1'b0;
    tick(1);
    check("one_push_count", {29'h0, fifo_count}, 32'h1);
    z80_read(8'h5A);
    check("pop_count", {29'h0, fifo_count}, 32'h0);
    check("pop_irq_still_lo", {31'h0, z80_irq_n}, 32'h0);
    tick(1);
    check("pop_irq_hi", {31'h0, z80_irq_n}, 32'h1);
    check("last_rd_dout", {24'h0, z80_dout}, 32'h5A);

    // Simultaneous push and pop with count=2
    m68k_write(8'hAA, 2);
    m68k_write(8'hBB, 2);
    exp_q.push_back(8'hAA);
    z80_latch_cs = 1'b1; RD_n = 1'b0;
    tick(2);
    RD_n = 1'b1; z80_latch_cs = 1'b0;
    m68k_din = 8'hCC; m68k_latch_cs = 1'b1;
    tick(1);
    check("simul_count", {29'h0, fifo_count}, 32'h2);
    m68k_latch_cs = 1'b0;
    tick(1);
    z80_read(8'hBB);
    z80_read(8'hCC);
    check("simul_drain_count", {29'h0, fifo_count}, 32'h0);

    // Empty FIFO: read edge coinciding with push is push only
    exp_q.push_back(8'hCC);
    z80_latch_cs = 1'b1; RD_n = 1'b0;
    tick(2);
    RD_n = 1'b1; z80_latch_cs = 1'b0;
    m68k_din = 8'h77; m68k_latch_cs = 1'b1;
    tick(1);
    check("empty_simul_count", {29'h0, fifo_count}, 32'h1);
    check("empty_simul_head", {24'h0, z80_dout}, 32'h77);
    m68k_latch_cs = 1'b0;
    tick(1);
    z80_read(8'h77);

    // Full FIFO: pop and push on the same edge, no overflow
    m68k_write(8'h11, 1);
    m68k_write(8'h22, 1);
    m68k_write(8'h33, 1);
    m68k_write(8'h44, 1);
    check("full_count", {29'h0, fifo_count}, 32'h4);
    exp_q.push_back(8'h11);
    z80_latch_cs = 1'b1; RD_n = 1'b0;
    tick(2);
    RD_n = 1'b1; z80_latch_cs = 1'b0;
    m68k_din = 8'h55; m68k_latch_cs = 1'b1;
    tick(1);
    check("full_simul_count", {29'h0, fifo_count}, 32'h4);
    check("full_simul_no_ovf", {31'h0, overflow}, 32'h0);
    m68k_latch_cs = 1'b0;
    tick(1);
    z80_read(8'h22);
    z80_read(8'h33);
    z80_read(8'h44);
    z80_read(8'h55);

    // Overflow: five writes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) m68k_write(8'(i), 2);
    check("ovf_count", {29'h0, fifo_count}, 32'h4);
    check("ovf_flag", {31'h0, overflow}, 32'h1);
    for (int i = 1; i <= 4; i++) z80_read(8'(i));
    z80_read(8'h04);
    check("empty_pop_count", {29'h0, fifo_count}, 32'h0);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);

`ifdef SOUND_REPLY_EN
    z80_din = 8'hA5; z80_latch_cs = 1'b1; WR_n = 1'b0;
    tick(1);
    check("reply_byte", {24'h0, m68k_reply}, 32'hA5);
    check("reply_set", {31'h0, reply_pending}, 32'h1);
    WR_n = 1'b1; z80_latch_cs = 1'b0;
    tick(1);
    m68k_reply_cs = 1'b1;
    tick(1);
    check("reply_clr", {31'h0, reply_pending}, 32'h0);
    m68k_reply_cs = 1'b0;
    tick(1);
`else
    z80_latch_cs = 1'b1; WR_n = 1'b0;
    tick(1);
    WR_n = 1'b1; z80_latch_cs = 1'b0; m68k_reply_cs = 1'b1;
    tick(1);
    m68k_reply_cs = 1'b0;
    check("noreply_byte", {24'h0, m68k_reply}, 32'h0);
    check("noreply_pending", {31'h0, reply_pending}, 32'h0);
`endif

    // Asynchronous mid-operation reset
    m68k_write(8'h99, 1);
    m68k_write(8'h98, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", {29'h0, fifo_count}, 32'h0);
    check("async_rst_ovf", {31'h0, overflow}, 32'h0);
    check("async_rst_irq", {31'h0, z80_irq_n}, 32'h1);
    check("async_rst_dout", {24'h0, z80_dout}, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
